// File: rtl/cw_key_debounce_repeat_if.sv
`default_nettype none
// ============================================================================
// Module      : cw_key_debounce_repeat_if
// Description : Key bundle between the board keys and the debounce/repeat block.
// Revision    : 1.0 - initial release
// ============================================================================
interface cw_key_debounce_repeat_if #(
  parameter int NKEY = 2
);
  logic [NKEY-1:0] i_Key;
  logic [NKEY-1:0] o_Level;
  logic [NKEY-1:0] o_Press;
  logic [NKEY-1:0] o_Release;
  logic [NKEY-1:0] o_Step;

  modport master (output i_Key, input o_Level, o_Press, o_Release, o_Step);
  modport slave  (input i_Key, output o_Level, o_Press, o_Release, o_Step);
endinterface
`default_nettype wire

// File: rtl/cw_key_debounce_repeat.sv
`default_nettype none
// ============================================================================
// Module      : cw_key_debounce_repeat
// Description : Per-key synchronizer, debouncer, press/release pulses and an
//               optional auto-repeat step generator (macro CW_KEY_AUTOREPEAT_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module cw_key_debounce_repeat #(
  parameter int NKEY          = 2,
  parameter int DEB_CYCLES    = 20,
  parameter int REPEAT_DELAY  = 500,
  parameter int REPEAT_PERIOD = 100
) (
  input  wire logic               Clk,
  input  wire logic               pRst,
  cw_key_debounce_repeat_if.slave key_bus
);

  localparam logic [7:0] c_DEB_LAST = 8'(DEB_CYCLES - 1);

  logic [NKEY-1:0] w_level;
  logic [NKEY-1:0] w_press;
  logic [NKEY-1:0] w_release;
  logic [NKEY-1:0] w_step;

`ifdef CW_KEY_AUTOREPEAT_EN
  localparam logic [15:0] c_DELAY_LAST  = 16'(REPEAT_DELAY - 1);
  localparam logic [15:0] c_PERIOD_LAST = 16'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } rpt_state_t;

  // More than one key held: x & (x-1) is nonzero iff at least two bits are set.
  logic w_chord;
  assign w_chord = |(w_level & (w_level - NKEY'(1)));
`else
  logic w_unused_repeat_cfg;
  assign w_unused_repeat_cfg = (REPEAT_DELAY > REPEAT_PERIOD);
`endif

  for (genvar k = 0; k < NKEY; k++) begin : g_key
    logic [1:0] r_sync;
    logic [7:0] r_deb_cnt;
    logic       r_level;
    logic       r_press;
    logic       r_release;
    logic       w_s;

    assign w_s = r_sync[1];

    always_ff @(posedge Clk or posedge pRst) begin
      if (pRst) begin
        r_sync    <= 2'b00;
        r_deb_cnt <= 8'd0;
        r_level   <= 1'b0;
        r_press   <= 1'b0;
        r_release <= 1'b0;
      end else begin
        r_sync    <= {r_sync[0], ~key_bus.i_Key[k]};
        r_press   <= 1'b0;
        r_release <= 1'b0;
        if (w_s == r_level) begin
          r_deb_cnt <= 8'd0;
        end else if (r_deb_cnt == c_DEB_LAST) begin
          r_level   <= w_s;
          r_deb_cnt <= 8'd0;
          r_press   <= w_s;
          r_release <= ~w_s;
        end else begin
          r_deb_cnt <= r_deb_cnt + 8'd1;
        end
      end
    end

    assign w_level[k]   = r_level;
    assign w_press[k]   = r_press;
    assign w_release[k] = r_release;

`ifdef CW_KEY_AUTOREPEAT_EN
    rpt_state_t  r_state;
    rpt_state_t  w_state_nxt;
    logic [15:0] r_rpt_cnt;
    logic [15:0] w_rpt_cnt_nxt;
    logic        w_rpt_step;

    always_ff @(posedge Clk or posedge pRst) begin
      if (pRst) begin
        r_state   <= ST_IDLE;
        r_rpt_cnt <= 16'd0;
      end else begin
        r_state   <= w_state_nxt;
        r_rpt_cnt <= w_rpt_cnt_nxt;
      end
    end

    // Release wins over a simultaneous expiry; a chord freezes the count.
    always_comb begin
      w_state_nxt   = r_state;
      w_rpt_cnt_nxt = r_rpt_cnt;
      w_rpt_step    = 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (r_press) begin
            w_state_nxt   = ST_DELAY;
            w_rpt_cnt_nxt = 16'd0;
          end
        end
        ST_DELAY: begin
          if (r_release) begin
            w_state_nxt   = ST_IDLE;
            w_rpt_cnt_nxt = 16'd0;
          end else if (!w_chord) begin
            if (r_rpt_cnt == c_DELAY_LAST) begin
              w_state_nxt   = ST_REPEAT;
              w_rpt_cnt_nxt = 16'd0;
              w_rpt_step    = 1'b1;
            end else begin
              w_rpt_cnt_nxt = r_rpt_cnt + 16'd1;
            end
          end
        end
        ST_REPEAT: begin
          if (r_release) begin
            w_state_nxt   = ST_IDLE;
            w_rpt_cnt_nxt = 16'd0;
          end else if (!w_chord) begin
            if (r_rpt_cnt == c_PERIOD_LAST) begin
              w_rpt_cnt_nxt = 16'd0;
              w_rpt_step    = 1'b1;
            end else begin
              w_rpt_cnt_nxt = r_rpt_cnt + 16'd1;
            end
          end
        end
        default: begin
          w_state_nxt   = ST_IDLE;
          w_rpt_cnt_nxt = 16'd0;
        end
      endcase
    end

    assign w_step[k] = r_press | w_rpt_step;
`else
    assign w_step[k] = r_press;
`endif
  end

  assign key_bus.o_Level   = w_level;
  assign key_bus.o_Press   = w_press;
  assign key_bus.o_Release = w_release;
  assign key_bus.o_Step    = w_step;

endmodule
`default_nettype wire

// File: tb/tb_cw_key_debounce_repeat.sv
`default_nettype none
// ============================================================================
// Module      : tb_cw_key_debounce_repeat
// Description : Directed and random stimulus against an event-level key model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cw_key_debounce_repeat;
  localparam int NKEY = 2;
  localparam int DEB  = 4;
  localparam int RD   = 10;
  localparam int RP   = 5;
`ifdef CW_KEY_AUTOREPEAT_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic Clk = 1'b0;
  logic pRst;
  always #5 Clk = ~Clk;

  cw_key_debounce_repeat_if #(.NKEY(NKEY)) bus ();

  cw_key_debounce_repeat #(
    .NKEY(NKEY), .DEB_CYCLES(DEB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .Clk(Clk), .pRst(pRst), .key_bus(bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [NKEY-1:0] key_drv;
  assign bus.i_Key = key_drv;

  // Model: raw pressed history (bit0 newest), accepted level, hold bookkeeping.
  logic [15:0]     hist [NKEY];
  logic [NKEY-1:0] m_level, m_press, m_release, m_step;
  bit              held [NKEY];
  int              elapsed [NKEY];
  int              obs_step [NKEY];
  int              obs_press [NKEY];
  int              obs_rel [NKEY];

  task automatic model_reset();
    for (int k = 0; k < NKEY; k++) begin
      hist[k] = '0; held[k] = 1'b0; elapsed[k] = 0;
    end
    m_level = '0; m_press = '0; m_release = '0; m_step = '0;
  endtask

  task automatic model_update();
    logic [15:0] win;
    logic [15:0] full;
    int          nheld;
    full = 16'((1 << DEB) - 1);
    m_press = '0; m_release = '0; m_step = '0;
    for (int k = 0; k < NKEY; k++) begin
      hist[k] = {hist[k][14:0], ~key_drv[k]};
      win = (hist[k] >> 2) & full;
      if (!m_level[k] && win == full) begin
        m_level[k] = 1'b1; m_press[k] = 1'b1;
      end else if (m_level[k] && win == 16'd0) begin
        m_level[k] = 1'b0; m_release[k] = 1'b1;
      end
    end
    nheld = $countones(m_level);
    for (int k = 0; k < NKEY; k++) begin
      if (m_press[k]) begin
        held[k] = 1'b1; elapsed[k] = 0; m_step[k] = 1'b1;
      end else if (held[k]) begin
        if (m_release[k]) begin
          held[k] = 1'b0;
        end else if (nheld <= 1) begin
          elapsed[k]++;
          m_step[k] = AUTO && (elapsed[k] == RD ||
                      (elapsed[k] > RD && (elapsed[k] - RD) % RP == 0));
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    n_checks++;
    assert (bus.o_Level === m_level) n_pass++;
    else $error("FAIL %s level got=%b exp=%b t=%0t", tag, bus.o_Level, m_level, $time);
    n_checks++;
    assert (bus.o_Press === m_press) n_pass++;
    else $error("FAIL %s press got=%b exp=%b t=%0t", tag, bus.o_Press, m_press, $time);
    n_checks++;
    assert (bus.o_Release === m_release) n_pass++;
    else $error("FAIL %s release got=%b exp=%b t=%0t", tag, bus.o_Release, m_release, $time);
    n_checks++;
    assert (bus.o_Step === m_step) n_pass++;
    else $error("FAIL %s step got=%b exp=%b t=%0t", tag, bus.o_Step, m_step, $time);
    for (int k = 0; k < NKEY; k++) begin
      obs_step[k]  += int'(bus.o_Step[k]);
      obs_press[k] += int'(bus.o_Press[k]);
      obs_rel[k]   += int'(bus.o_Release[k]);
    end
  endtask

  task automatic clear_obs();
    for (int k = 0; k < NKEY; k++) begin
      obs_step[k] = 0; obs_press[k] = 0; obs_rel[k] = 0;
    end
  endtask

  task automatic cycles(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(posedge Clk);
      if (pRst) model_reset();
      else model_update();
      #1;
      check_all(tag);
    end
  endtask

  task automatic count_check(input string tag, input int got, input int exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s count got=%0d exp=%0d", tag, got, exp);
  endtask

  // Asynchronous assertion: outputs must drop before any clock edge.
  task automatic reset_pulse(input int hold_edges, input string tag);
    pRst = 1'b1;
    #1;
    model_reset();
    check_all(tag);
    cycles(hold_edges, tag);
    pRst = 1'b0;
  endtask

  initial begin
    int rem [NKEY];
    key_drv = '1;
    pRst    = 1'b1;
    model_reset();
    #2;
    check_all("reset_init");
    cycles(3, "reset_hold");
    pRst = 1'b0;
    cycles(8, "idle");

    // Single key held 40 cycles
    clear_obs();
    key_drv[0] = 1'b0;
    cycles(40, "hold40");
    key_drv[0] = 1'b1;
    cycles(20, "hold40_rel");
    count_check("hold40_steps", obs_step[0], AUTO ? 7 : 1);
    count_check("hold40_press", obs_press[0], 1);
    count_check("hold40_release", obs_rel[0], 1);

    // Glitches of DEB-1 samples never get accepted
    clear_obs();
    for (int r = 0; r < 5; r++) begin
      key_drv[0] = 1'b0;
      cycles(3, "glitch_lo");
      key_drv[0] = 1'b1;
      cycles(3, "glitch_hi");
    end
    cycles(6, "glitch_end");
    count_check("glitch_press", obs_press[0], 0);

    // Chord: both keys, no auto-repeat
    clear_obs();
    key_drv = '0;
    cycles(40, "chord");
    key_drv = '1;
    cycles(20, "chord_rel");
    count_check("chord_step0", obs_step[0], 1);
    count_check("chord_step1", obs_step[1], 1);

    // Key 1 alone
    clear_obs();
    key_drv[1] = 1'b0;
    cycles(40, "key1_hold");
    key_drv[1] = 1'b1;
    cycles(20, "key1_rel");
    count_check("key1_press", obs_press[1], 1);
    count_check("key1_steps", obs_step[1], AUTO ? 7 : 1);

    // Reset mid-hold
    key_drv[0] = 1'b0;
    cycles(20, "midhold");
    clear_obs();
    reset_pulse(2, "midhold_rst");
    cycles(15, "midhold_after");
    count_check("midhold_release", obs_rel[0], 0);
    count_check("midhold_press", obs_press[0], 1);
    count_check("midhold_step", obs_step[0], 1);
    key_drv[0] = 1'b1;
    cycles(15, "midhold_rel");

    // Random hold/glitch lengths per key, occasional reset
    for (int k = 0; k < NKEY; k++) rem[k] = $urandom_range(1, 40);
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < NKEY; k++) begin
        rem[k]--;
        if (rem[k] <= 0) begin
          key_drv[k] = ~key_drv[k];
          rem[k] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5)
                                               : $urandom_range(1, 45);
        end
      end
      if ($urandom_range(0, 599) == 0) reset_pulse($urandom_range(1, 3), "rand_rst");
      cycles(1, "random");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
